// File: rtl/buffer_linea_param.sv
// ---------------------------------------------------------------------------
// buffer_linea_param
//
// A line-buffer stage for the filter's row-buffer chain. Each unit owns a
// synchronous FIFO of 2**ADDR_WIDTH words. A three-state activation FSM
// selects what the unit does:
//   LIBRE     - idle; FIFO is cleared and requests are ignored
//   ACTIVA    - pixels are stored and later read back in FIFO order
//   NO_ACTIVA - pixels are forwarded to data_out with one cycle of latency
//
// Optional feature macro: BUFFER_LINEA_ERROR_EN
//   When defined, 'error' is a sticky misuse flag. It is set by a write
//   rejected on a full FIFO in ACTIVA, a read rejected on an empty FIFO in
//   ACTIVA, or any read_req in NO_ACTIVA. It clears on reset or on entering
//   LIBRE. When undefined, 'error' is tied to 0.
//
// Ports
//   clk              clock, rising edge
//   reset            synchronous active-high reset, overrides all inputs
//   data_in          pixel to store (ACTIVA) or forward (NO_ACTIVA)
//   write_req        write / forward strobe
//   read_req         read strobe (ACTIVA only)
//   valor_activacion 00 hold, 01 activate, 10 bypass, 11 release/flush
//   data_out         registered read or bypass data
//   data_valid       data_out was updated this cycle
//   fifo_full        usedw == DEPTH
//   fifo_empty       usedw == 0
//   usedw            stored word count, 0..DEPTH
//   estado_activo    state is ACTIVA
//   error            sticky misuse flag
// ---------------------------------------------------------------------------
module buffer_linea_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_req,
    input  logic                  read_req,
    input  logic [1:0]            valor_activacion,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  estado_activo,
    output logic                  error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        LIBRE     = 2'd0,
        ACTIVA    = 2'd1,
        NO_ACTIVA = 2'd2
    } estado_t;

    estado_t state_reg, state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_WIDTH:0]   usedw_reg, usedw_next;
    logic                  full_reg, empty_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  data_valid_reg;

    logic rd_acc, wr_acc, byp_acc;

    // ---------------- activation FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= LIBRE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = LIBRE;
        case (state_reg)
            LIBRE: begin
                case (valor_activacion)
                    2'b01:   state_next = ACTIVA;
                    2'b10:   state_next = NO_ACTIVA;
                    default: state_next = LIBRE;
                endcase
            end
            ACTIVA:    state_next = (valor_activacion == 2'b11) ? LIBRE : ACTIVA;
            NO_ACTIVA: state_next = (valor_activacion == 2'b11) ? LIBRE : NO_ACTIVA;
            default:   state_next = LIBRE;
        endcase
    end

    // ---------------- request qualification ----------------
    // Requests are judged against the current (old) state. A write on a full
    // FIFO is still accepted when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc  = (state_reg == ACTIVA) && read_req && !empty_reg;
        wr_acc  = (state_reg == ACTIVA) && write_req && (!full_reg || rd_acc);
        byp_acc = (state_reg == NO_ACTIVA) && write_req;
    end

    always_comb begin
        usedw_next = usedw_reg;
        case ({wr_acc, rd_acc})
            2'b10:   usedw_next = usedw_reg + 1'b1;
            2'b01:   usedw_next = usedw_reg - 1'b1;
            default: usedw_next = usedw_reg;
        endcase
    end

    // ---------------- pointers and fill level ----------------
    // Any transition into LIBRE flushes the FIFO bookkeeping; the memory
    // contents are left as-is since they become unreachable.
    always_ff @(posedge clk) begin
        if (reset || state_next == LIBRE) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            usedw_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_acc) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            usedw_reg <= usedw_next;
            full_reg  <= (usedw_next == DEPTH_CNT);
            empty_reg <= (usedw_next == '0);
        end
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    // Registered read port shared with the bypass path. On a full-FIFO
    // simultaneous read/write the pointers coincide and the read returns the
    // old word (read-before-write).
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            data_valid_reg <= rd_acc || byp_acc;
            if (rd_acc) begin
                data_out_reg <= mem[rd_ptr_reg];
            end else if (byp_acc) begin
                data_out_reg <= data_in;
            end
        end
    end

    // ---------------- optional misuse flag ----------------
`ifdef BUFFER_LINEA_ERROR_EN
    logic error_reg;
    logic err_set;

    always_comb begin
        err_set = 1'b0;
        if (state_reg == ACTIVA) begin
            err_set = (write_req && !wr_acc) || (read_req && !rd_acc);
        end else if (state_reg == NO_ACTIVA) begin
            err_set = read_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state_next == LIBRE) begin
            error_reg <= 1'b0;
        end else if (err_set) begin
            error_reg <= 1'b1;
        end
    end

    assign error = error_reg;
`else
    assign error = 1'b0;
`endif

    assign data_out      = data_out_reg;
    assign data_valid    = data_valid_reg;
    assign fifo_full     = full_reg;
    assign fifo_empty    = empty_reg;
    assign usedw         = usedw_reg;
    assign estado_activo = (state_reg == ACTIVA);

endmodule

// File: tb/tb_buffer_linea_param.sv
// ---------------------------------------------------------------------------
// tb_buffer_linea_param
//
// Self-checking bench for buffer_linea_param (DATA_WIDTH 8, ADDR_WIDTH 3).
// A queue-based reference model predicts the outputs after every edge.
// Honours BUFFER_LINEA_ERROR_EN when predicting the error output.
// ---------------------------------------------------------------------------
module tb_buffer_linea_param;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

`ifdef BUFFER_LINEA_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          write_req = 1'b0;
    logic          read_req = 1'b0;
    logic [1:0]    valor_activacion = 2'b00;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   usedw;
    logic          estado_activo;
    logic          error;

    buffer_linea_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .data_in          (data_in),
        .write_req        (write_req),
        .read_req         (read_req),
        .valor_activacion (valor_activacion),
        .data_out         (data_out),
        .data_valid       (data_valid),
        .fifo_full        (fifo_full),
        .fifo_empty       (fifo_empty),
        .usedw            (usedw),
        .estado_activo    (estado_activo),
        .error            (error)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    // m_state: 0 idle, 1 storing, 2 forwarding
    int            m_state = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout  = '0;
    logic          m_valid = 1'b0;
    logic          m_err   = 1'b0;

    task automatic model_update(input logic r, input logic [1:0] code,
                                input logic wr, input logic rd,
                                input logic [DW-1:0] din);
        int  ns;
        bit  rd_ok, wr_ok;
        if (r) begin
            m_state = 0; q.delete(); m_dout = '0; m_valid = 1'b0; m_err = 1'b0;
            return;
        end
        m_valid = 1'b0;
        ns = m_state;
        case (m_state)
            0: begin
                if (code == 2'b01) ns = 1;
                else if (code == 2'b10) ns = 2;
            end
            1: begin
                rd_ok = rd && (q.size() > 0);
                wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
                if (ERR_EN && ((wr && !wr_ok) || (rd && !rd_ok))) m_err = 1'b1;
                if (rd_ok) begin m_dout = q.pop_front(); m_valid = 1'b1; end
                if (wr_ok) q.push_back(din);
                if (code == 2'b11) ns = 0;
            end
            default: begin
                if (wr) begin m_dout = din; m_valid = 1'b1; end
                if (ERR_EN && rd) m_err = 1'b1;
                if (code == 2'b11) ns = 0;
            end
        endcase
        if (ns == 0) begin q.delete(); m_err = 1'b0; end
        m_state = ns;
    endtask

    function automatic logic [16:0] exp_vec();
        logic [AW:0] cnt;
        cnt = (AW + 1)'(q.size());
        return {m_dout, m_valid, (q.size() == DEPTH), (q.size() == 0), cnt,
                (m_state == 1), m_err};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {data_out, data_valid, fifo_full, fifo_empty, usedw, estado_activo, error};
    endfunction

    // One clock of stimulus: drive, advance the model, sample 1 ns after the edge.
    task automatic step(input logic r, input logic [1:0] code, input logic wr,
                        input logic rd, input logic [DW-1:0] din);
        reset = r; valor_activacion = code; write_req = wr; read_req = rd; data_in = din;
        model_update(r, code, wr, rd, din);
        @(posedge clk);
        #1;
        $display("txn t=%0t rst=%0b code=%0d wr=%0b rd=%0b din=%02h -> dout=%02h v=%0b used=%0d",
                 $time, r, code, wr, rd, din, data_out, data_valid, usedw);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if ({data_out, data_valid, fifo_full, fifo_empty, usedw, estado_activo, error}
            !== {8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values got=%05h want=%05h", dut_vec(),
                     {8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_fill_full();
        step(1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (estado_activo !== 1'b1) begin
            n_fail++; $display("FAIL activate estado_activo got=%0b want=1", estado_activo);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 2'b00, 1'b1, 1'b0, 8'h10 + 8'(i));
            n_cmp++;
            if (usedw !== 4'(i + 1)) begin
                n_fail++; $display("FAIL fill_usedw[%0d] got=%0d want=%0d", i, usedw, i + 1);
            end
        end
        n_cmp++;
        if (fifo_full !== 1'b1 || fifo_empty !== 1'b0) begin
            n_fail++; $display("FAIL fill_flags got full=%0b empty=%0b want full=1 empty=0",
                               fifo_full, fifo_empty);
        end
        step(1'b0, 2'b00, 1'b1, 1'b0, 8'hFF);
        n_cmp++;
        if (usedw !== 4'd8 || error !== ERR_EN) begin
            n_fail++; $display("FAIL ninth_write got used=%0d err=%0b want used=8 err=%0b",
                               usedw, error, ERR_EN);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 2'b00, 1'b0, 1'b1, 8'h00);
            n_cmp++;
            if (data_out !== 8'h10 + 8'(i) || data_valid !== 1'b1) begin
                n_fail++; $display("FAIL drain[%0d] got dout=%02h v=%0b want dout=%02h v=1",
                                   i, data_out, data_valid, 8'h10 + 8'(i));
            end
        end
        n_cmp++;
        if (fifo_empty !== 1'b1 || usedw !== 4'd0) begin
            n_fail++; $display("FAIL drain_empty got empty=%0b used=%0d want empty=1 used=0",
                               fifo_empty, usedw);
        end
        // Idle cycle: valid must drop, data must hold
        step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL drain_idle got=%05h want=%05h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_simul_rw();
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'b00, 1'b1, 1'b1, 8'($urandom));
            n_cmp++;
            if (data_out !== m_dout || data_valid !== 1'b1 || usedw !== 4'd4) begin
                n_fail++; $display("FAIL simul_rw[%0d] got dout=%02h v=%0b used=%0d want dout=%02h v=1 used=4",
                                   i, data_out, data_valid, usedw, m_dout);
            end
        end
    endtask

    task automatic test_bypass();
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 2'b10, 1'b0, 1'b0, 8'h00);
        step(1'b0, 2'b00, 1'b1, 1'b0, 8'hA5);
        n_cmp++;
        if (data_out !== 8'hA5 || data_valid !== 1'b1 || usedw !== 4'd0 ||
            fifo_empty !== 1'b1 || fifo_full !== 1'b0 || estado_activo !== 1'b0) begin
            n_fail++; $display("FAIL bypass got=%05h want dout=a5 v=1 used=0 empty=1", dut_vec());
        end
        step(1'b0, 2'b11, 1'b0, 1'b0, 8'h00);
        step(1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (estado_activo !== 1'b1 || fifo_empty !== 1'b1 || usedw !== 4'd0) begin
            n_fail++; $display("FAIL bypass_to_activa got act=%0b empty=%0b used=%0d want 1/1/0",
                               estado_activo, fifo_empty, usedw);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 1'b1, 1'b0, 8'($urandom));
        step(1'b0, 2'b00, 1'b0, 1'b1, 8'h00);
        n_cmp++;
        if (usedw !== 4'd4 || data_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset got used=%0d v=%0b want used=4 v=1", usedw, data_valid);
        end
        step(1'b0, 2'b00, 1'b1, 1'b0, 8'h5A);
        step(1'b1, 2'b01, 1'b1, 1'b1, 8'h77);
        n_cmp++;
        if (dut_vec() !== {8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_mid got=%05h want=%05h", dut_vec(),
                               {8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_error();
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        step(1'b0, 2'b00, 1'b0, 1'b1, 8'h00);
        n_cmp++;
        if (error !== ERR_EN || data_valid !== 1'b0) begin
            n_fail++; $display("FAIL err_empty_read got err=%0b v=%0b want err=%0b v=0",
                               error, data_valid, ERR_EN);
        end
        step(1'b0, 2'b00, 1'b1, 1'b0, 8'h33);
        n_cmp++;
        if (error !== ERR_EN) begin
            n_fail++; $display("FAIL err_sticky got=%0b want=%0b", error, ERR_EN);
        end
        step(1'b0, 2'b11, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (error !== 1'b0 || usedw !== 4'd0) begin
            n_fail++; $display("FAIL err_release got err=%0b used=%0d want err=0 used=0", error, usedw);
        end
        step(1'b0, 2'b10, 1'b0, 1'b0, 8'h00);
        step(1'b0, 2'b00, 1'b0, 1'b1, 8'h00);
        n_cmp++;
        if (error !== ERR_EN) begin
            n_fail++; $display("FAIL err_bypass_read got=%0b want=%0b", error, ERR_EN);
        end
    endtask

    task automatic test_random();
        logic [1:0] code;
        int         sel;
        logic       r;
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 400; i++) begin
            sel  = int'($urandom_range(0, 19));
            code = (sel == 0) ? 2'b11 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b10 : 2'b00;
            r    = ($urandom_range(0, 59) == 0);
            step(r, code, 1'($urandom), 1'($urandom), 8'($urandom));
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random[%0d] got=%05h want=%05h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_drain();
        test_simul_rw();
        test_bypass();
        test_reset_mid();
        test_error();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/buffer_linea_param.md
# buffer_linea_param

Parametrised line-buffer unit for the row-buffer chain of the filter architecture. It owns its storage: a synchronous FIFO of 2^ADDR_WIDTH words of DATA_WIDTH bits. A three-state activation FSM decides whether the unit stores pixels, passes them straight through, or sits idle. Several units are chained so that the total row length matches the image width. Units in NO_ACTIVA forward pixels with one cycle of latency, and units in ACTIVA hold pixels until they are read.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- ADDR_WIDTH, 3, FIFO address width; DEPTH = 2^ADDR_WIDTH words
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- data_in  in  DATA_WIDTH  pixel to store (ACTIVA) or forward (NO_ACTIVA)
- write_req  in  1  write/forward strobe
- read_req  in  1  read strobe, used in ACTIVA only
- valor_activacion  in  2  00 hold, 01 activate, 10 deactivate (bypass), 11 release/flush
- data_out  out  DATA_WIDTH  registered read or bypass data
- data_valid  out  1  data_out was updated this cycle
- fifo_full  out  1  usedw == DEPTH
- fifo_empty  out  1  usedw == 0
- usedw  out  ADDR_WIDTH+1  stored word count, 0..DEPTH
- estado_activo  out  1  high when the state is ACTIVA
- error  out  1  sticky misuse flag (see Configuration)

## Operation
- States: LIBRE (0), ACTIVA (1), NO_ACTIVA (2). Encoding 3 is illegal and goes to LIBRE on the next edge.
- LIBRE: 01 goes to ACTIVA, 10 goes to NO_ACTIVA, 00 and 11 stay in LIBRE. read_req and write_req are ignored.
- ACTIVA and NO_ACTIVA: 11 goes to LIBRE, 00/01/10 hold the state. Moving directly between ACTIVA and NO_ACTIVA is not allowed and needs a pass through LIBRE.
- Entering LIBRE, whether by 11 or by reset, clears both pointers and usedw. Stored data is discarded and the memory contents are don't-care.
- ACTIVA write: an accepted write (write_req and not full) stores data_in at wr_ptr and increments wr_ptr.
- ACTIVA read: an accepted read (read_req and not empty) loads data_out with mem[rd_ptr], increments rd_ptr and drives data_valid high for one cycle.
- Pointers are ADDR_WIDTH bits wide and wrap naturally from DEPTH-1 to 0.
- Simultaneous read and write when full: both are accepted and usedw stays at DEPTH.
- Simultaneous read and write when empty: only the write is accepted (no fall-through) and usedw becomes 1.
- Simultaneous read and write in any other state of fill: both are accepted and usedw is unchanged.
- Rejected read: data_out holds its last value and data_valid stays 0. A rejected write leaves memory unchanged.
- NO_ACTIVA: write_req causes data_out <= data_in and data_valid = 1 on the next cycle. The FIFO is never touched; usedw stays 0, fifo_empty=1, fifo_full=0.
- The state register updates on the clock edge. A request arriving in the same cycle as an activation code is handled under the old state.

## Timing
- Reset values: state LIBRE, data_out 0, data_valid 0, fifo_full 0, fifo_empty 1, usedw 0, estado_activo 0, error 0.
- Reset asserted mid-operation clears everything at the next edge, regardless of requests or valor_activacion.
- Read latency is 1 cycle: read_req at edge N gives data_out/data_valid after edge N.
- Bypass latency is 1 cycle.
- Flags and usedw are registered. They reflect all accepted operations up to the last edge, so fifo_empty falls one cycle after the first write.
- Maximum throughput is one read and one write per cycle.

## Configuration
- Macro BUFFER_LINEA_ERROR_EN controls the error output.
- Defined: error is set when either of these occurs, and stays set until reset or until the state enters LIBRE:
  - a write is rejected because the FIFO is full in ACTIVA;
  - a read is rejected because the FIFO is empty in ACTIVA.
- Also defined: read_req in NO_ACTIVA sets error.
- Not defined: the error port still exists and is tied to 0. No error logic is synthesised.

## Test plan
- Reset, then 01, then write 8 words 0x10..0x17 (DEPTH 8): fifo_full=1 and usedw=8. A ninth write 0xFF is rejected.
- Read 8 words from the full FIFO: the sequence 0x10..0x17 appears, each with data_valid, 1 cycle after its read_req. fifo_empty=1 afterwards.
- In ACTIVA with 4 stored words, assert read and write together for 20 cycles: usedw stays 4, the pointers wrap, and the output order is FIFO.
- Reset, then 10, then write 0xA5: data_out=0xA5 and data_valid=1 on the next cycle, usedw=0. Then send 11 followed by 01: the state is ACTIVA with the FIFO empty.
- With usedw=5, assert reset while write_req is high: all outputs return to their reset values after one edge.
- With the macro defined, read when empty in ACTIVA: error=1 and stays 1; after 11, error=0. Without the macro, error is always 0.
